// File: rtl/omsp_sram_arb_if.sv
// Bus bundle between the CPU data port, the secondary master and the SRAM controller.
// The arbiter takes the slave view; the environment drives through the master view.
interface omsp_sram_arb_if #(parameter int ADDR_WIDTH = 9);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_cen;
  logic [1:0]            cpu_wen;
  logic [15:0]           cpu_din;
  logic [15:0]           cpu_dout;
  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [1:0]            b_wen;
  logic [15:0]           b_din;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [15:0]           b_rdata;
  logic                  b_starve;
  logic                  b_clr_starve;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cen;
  logic [1:0]            mem_wen;
  logic [15:0]           mem_din;
  logic [15:0]           mem_dout;

  modport slave (
    input  cpu_addr, cpu_cen, cpu_wen, cpu_din,
    input  b_req, b_addr, b_wen, b_din, b_clr_starve,
    input  mem_dout,
    output cpu_dout, b_gnt, b_rvalid, b_rdata, b_starve,
    output mem_addr, mem_cen, mem_wen, mem_din
  );

  modport master (
    output cpu_addr, cpu_cen, cpu_wen, cpu_din,
    output b_req, b_addr, b_wen, b_din, b_clr_starve,
    output mem_dout,
    input  cpu_dout, b_gnt, b_rvalid, b_rdata, b_starve,
    input  mem_addr, mem_cen, mem_wen, mem_din
  );
endinterface

// File: rtl/omsp_sram_arb.sv
// Shares one SRAM between the openMSP430 data port (absolute priority) and a
// secondary req/gnt master served in CPU-idle cycles, with starvation reporting.
module omsp_sram_arb #(
  parameter int ADDR_WIDTH = 9,
  parameter int STARVE_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  omsp_sram_arb_if.slave   bus
);
  logic        w_cpu_own, w_b_own;
  logic        r_cpu_rd_d, r_b_rd_d;
  logic [15:0] r_hold;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_starve;

  assign w_cpu_own = !rst && !bus.cpu_cen;
  assign w_b_own   = !rst &&  bus.cpu_cen && bus.b_req;

  // Idle cycles park address/data on the CPU values; only cen/wen are forced.
  assign bus.mem_addr = w_b_own ? bus.b_addr : bus.cpu_addr;
  assign bus.mem_din  = w_b_own ? bus.b_din  : bus.cpu_din;
  assign bus.mem_cen  = !(w_cpu_own || w_b_own);
  assign bus.mem_wen  = w_cpu_own ? bus.cpu_wen :
                        w_b_own   ? bus.b_wen   : 2'b11;
  assign bus.b_gnt    = w_b_own;

  assign bus.cpu_dout = r_cpu_rd_d ? bus.mem_dout : r_hold;
  assign bus.b_rvalid = r_b_rd_d;
  assign bus.b_rdata  = bus.mem_dout;
  assign bus.b_starve = r_starve;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_b_own)
      w_cnt_nxt = 8'd0;
    else if (bus.b_req && r_cnt != 8'hFF)
      w_cnt_nxt = r_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rd_d <= 1'b0;
      r_b_rd_d   <= 1'b0;
      r_hold     <= 16'h0000;
      r_cnt      <= 8'd0;
      r_starve   <= 1'b0;
    end else begin
      r_cpu_rd_d <= w_cpu_own && (bus.cpu_wen == 2'b11);
      r_b_rd_d   <= w_b_own   && (bus.b_wen   == 2'b11);
      if (r_cpu_rd_d)
        r_hold <= bus.mem_dout;
      // Clear takes precedence over a same-cycle threshold hit.
      if (bus.b_clr_starve) begin
        r_cnt    <= 8'd0;
        r_starve <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_cnt_nxt == 8'(STARVE_MAX))
          r_starve <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_omsp_sram_arb.sv
// Directed bench for omsp_sram_arb with a one-cycle-latency SRAM model behind it.
module tb_omsp_sram_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] ram [0:511];

  omsp_sram_arb_if #(.ADDR_WIDTH(9)) bus ();
  omsp_sram_arb #(.ADDR_WIDTH(9), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // SRAM controller model: data of an access appears one cycle later.
  always @(posedge clk) begin
    if (!bus.mem_cen) begin
      if (bus.mem_wen == 2'b11) bus.mem_dout <= ram[bus.mem_addr];
      else begin
        if (!bus.mem_wen[0]) ram[bus.mem_addr][7:0]  <= bus.mem_din[7:0];
        if (!bus.mem_wen[1]) ram[bus.mem_addr][15:8] <= bus.mem_din[15:8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.cpu_cen = 1'b1; bus.cpu_wen = 2'b11; bus.b_req = 1'b0; bus.b_wen = 2'b11;
  endtask

  function automatic logic [15:0] dat(input int i);
    return 16'(32'hA000 + i * 32'h0101);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] last_cpu;
    for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
    bus.mem_dout = 16'h5A5A;
    bus.b_clr_starve = 1'b0;
    bus.cpu_din = 16'h0; bus.b_din = 16'h0; bus.cpu_addr = '0; bus.b_addr = '0;

    // Reset with both masters requesting
    rst = 1'b1; bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b00; bus.b_req = 1'b1;
    #1;
    chk("rst_mem_cen", bus.mem_cen, 1);
    chk("rst_b_gnt", bus.b_gnt, 0);
    step(); step();
    chk("rst_mem_wen", bus.mem_wen, 2'b11);
    chk("rst_cpu_dout", bus.cpu_dout, 16'h0000);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_b_starve", bus.b_starve, 0);

    // CPU priority: CPU write to 5 while secondary wants to write 0xBEEF to 7
    rst = 1'b0;
    bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b00; bus.cpu_addr = 9'd5; bus.cpu_din = 16'h1234;
    bus.b_req = 1'b1; bus.b_wen = 2'b00; bus.b_addr = 9'd7; bus.b_din = 16'hBEEF;
    #1;
    chk("pri_b_gnt", bus.b_gnt, 0);
    chk("pri_mem_addr", bus.mem_addr, 5);
    chk("pri_mem_wen", bus.mem_wen, 2'b00);
    chk("pri_mem_din", bus.mem_din, 16'h1234);
    step();
    bus.cpu_cen = 1'b1; bus.cpu_wen = 2'b11;
    #1;
    chk("pend_b_gnt", bus.b_gnt, 1);
    chk("pend_mem_addr", bus.mem_addr, 7);
    chk("pend_mem_din", bus.mem_din, 16'hBEEF);
    chk("pend_mem_wen", bus.mem_wen, 2'b00);
    step();
    idle();
    chk("wr_no_rvalid", bus.b_rvalid, 0);
    #1;
    chk("idle_mem_cen", bus.mem_cen, 1);
    chk("idle_mem_addr", bus.mem_addr, 5);

    // CPU data hold across a secondary read
    bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b11; bus.cpu_addr = 9'd5;
    step();
    bus.cpu_cen = 1'b1; bus.b_req = 1'b1; bus.b_wen = 2'b11; bus.b_addr = 9'd7;
    #1;
    chk("hold_cpu_dout0", bus.cpu_dout, 16'h1234);
    chk("hold_b_gnt", bus.b_gnt, 1);
    step();
    idle();
    chk("hold_b_rvalid", bus.b_rvalid, 1);
    chk("hold_b_rdata", bus.b_rdata, 16'hBEEF);
    chk("hold_cpu_dout1", bus.cpu_dout, 16'h1234);
    step();
    chk("hold_b_rvalid_end", bus.b_rvalid, 0);
    chk("hold_cpu_dout2", bus.cpu_dout, 16'h1234);

    // Low-byte-only CPU write, then read back
    bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b10; bus.cpu_addr = 9'd5; bus.cpu_din = 16'hFFAB;
    step();
    bus.cpu_wen = 2'b11;
    step();
    idle();
    chk("byte_cpu_dout", bus.cpu_dout, 16'h12AB);
    last_cpu = 16'h12AB;

    // Preload 16..31, then alternate CPU and secondary reads every cycle
    for (int i = 0; i < 16; i++) begin
      bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b00; bus.cpu_addr = 9'(16 + i); bus.cpu_din = dat(i);
      step();
    end
    idle();
    step();
    chk("preload_cpu_dout", bus.cpu_dout, last_cpu);
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b11; bus.cpu_addr = 9'(16 + k); bus.b_req = 1'b0;
      end else begin
        bus.cpu_cen = 1'b1; bus.b_req = 1'b1; bus.b_wen = 2'b11; bus.b_addr = 9'(16 + k);
      end
      #1;
      chk("il_b_gnt", bus.b_gnt, 32'(k % 2));
      step();
      if (k % 2 == 0) begin
        last_cpu = dat(k);
        chk("il_cpu_dout", bus.cpu_dout, last_cpu);
        chk("il_no_rvalid", bus.b_rvalid, 0);
      end else begin
        chk("il_b_rvalid", bus.b_rvalid, 1);
        chk("il_b_rdata", bus.b_rdata, dat(k));
        chk("il_cpu_hold", bus.cpu_dout, last_cpu);
      end
    end
    idle();

    // Starvation with STARVE_MAX=4
    bus.cpu_cen = 1'b0; bus.cpu_wen = 2'b11; bus.cpu_addr = 9'd5; bus.b_req = 1'b1;
    step(); step(); step();
    chk("stv_3_denied", bus.b_starve, 0);
    step();
    chk("stv_4_denied", bus.b_starve, 1);
    step();
    chk("stv_sticky", bus.b_starve, 1);
    bus.b_clr_starve = 1'b1;
    step();
    bus.b_clr_starve = 1'b0;
    chk("stv_cleared", bus.b_starve, 0);
    step(); step(); step();
    chk("stv_restart_3", bus.b_starve, 0);
    step();
    chk("stv_restart_4", bus.b_starve, 1);
    // Clear on the same cycle the threshold is hit
    bus.b_clr_starve = 1'b1;
    step();
    bus.b_clr_starve = 1'b0;
    step(); step(); step();
    bus.b_clr_starve = 1'b1;
    step();
    bus.b_clr_starve = 1'b0;
    chk("stv_clear_wins", bus.b_starve, 0);
    // Grant clears the count
    step(); step(); step();
    bus.cpu_cen = 1'b1;
    step();
    bus.cpu_cen = 1'b0;
    step(); step(); step();
    chk("stv_gnt_resets", bus.b_starve, 0);
    step();
    chk("stv_after_gnt_4", bus.b_starve, 1);
    idle();

    // Reset during a secondary read request
    bus.cpu_cen = 1'b1; bus.b_req = 1'b1; bus.b_wen = 2'b11; bus.b_addr = 9'd7;
    rst = 1'b1;
    #1;
    chk("rstmid_b_gnt", bus.b_gnt, 0);
    chk("rstmid_mem_cen", bus.mem_cen, 1);
    step();
    rst = 1'b0; idle();
    chk("rstmid_b_rvalid", bus.b_rvalid, 0);
    chk("rstmid_cpu_dout", bus.cpu_dout, 16'h0000);
    chk("rstmid_b_starve", bus.b_starve, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/omsp_sram_arb.md
# omsp_sram_arb

Two-port arbiter placed between the openMSP430 data-memory interface and the external async SRAM controller, sharing one SRAM between the CPU and a secondary master such as a DMA or video fetch engine. The CPU port has absolute priority and never stalls. The secondary port is served only in CPU-idle cycles through a req/gnt handshake. The block routes read data back to the owner of each access, keeps the CPU's last read word stable across secondary accesses, and reports secondary-port starvation.

## Interface
- ADDR_WIDTH, 9: word address width on all ports.
- STARVE_MAX, 255: number of consecutive denied cycles that sets `b_starve`; range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_cen  in  1  CPU chip enable, active low.
- cpu_wen  in  2  CPU byte write enables, active low; `11` means read.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data.
- b_req  in  1  secondary request; level, held until granted.
- b_addr  in  ADDR_WIDTH  secondary word address.
- b_wen  in  2  secondary byte write enables, active low; `11` means read.
- b_din  in  16  secondary write data.
- b_gnt  out  1  request accepted this cycle.
- b_rvalid  out  1  secondary read data valid.
- b_rdata  out  16  secondary read data.
- b_starve  out  1  sticky starvation flag.
- b_clr_starve  in  1  clears `b_starve` and the starvation counter.
- mem_addr  out  ADDR_WIDTH  to SRAM controller.
- mem_cen  out  1  to SRAM controller, active low.
- mem_wen  out  2  to SRAM controller, active low.
- mem_din  out  16  to SRAM controller.
- mem_dout  in  16  from SRAM controller; valid one cycle after the access cycle.

## Operation
**Owner selection (combinational, per cycle)**
- `cpu_cen=0`: the CPU owns the cycle. `mem_*` take the `cpu_*` values. `b_gnt=0`.
- `cpu_cen=1` and `b_req=1`: the secondary port owns the cycle. `mem_*` take the `b_*` values. `b_gnt=1`.
- Otherwise the cycle is idle: `mem_cen=1`, `mem_wen=11`, and `mem_addr`/`mem_din` hold the CPU values.
- While `rst=1`: `mem_cen=1`, `mem_wen=11`, `b_gnt=0`, regardless of inputs.

**Read-return tracking**
- Two registered tag bits, `cpu_rd_d` and `b_rd_d`, record whether the previous cycle was a granted read (`wen=11`) by the CPU or by the secondary port.
- Writes never set either tag.

**CPU data path**
- `cpu_dout = mem_dout` when `cpu_rd_d=1`; otherwise `cpu_dout` = hold register.
- The hold register loads `mem_dout` at the end of every cycle with `cpu_rd_d=1`.
- Result: `cpu_dout` stays unchanged through secondary accesses and idle cycles.

**Secondary data path**
- `b_rvalid = b_rd_d`.
- `b_rdata = mem_dout` (only meaningful while `b_rvalid=1`).

**Starvation**
- An 8-bit saturating counter increments each cycle with `b_req=1` and `b_gnt=0`.
- The counter clears on any `b_gnt=1` cycle.
- When the counter reaches STARVE_MAX, `b_starve` is set and stays set until `b_clr_starve=1` or reset.
- If `b_clr_starve=1` in the same cycle the counter reaches STARVE_MAX, the clear wins.

## Timing
**Reset values** (synchronous, applied on the first edge with `rst=1`):
- `cpu_rd_d=0`, `b_rd_d=0`, hold register `0x0000`.
- Counter 0, `b_starve=0`.
- Consequently `cpu_dout=0x0000` and `b_rvalid=0` after reset.

**Grant**
- `b_gnt` is combinational: same cycle as the request if the CPU is idle. Zero added latency.
- The secondary master must sample `b_gnt` on the clock edge and then may change `b_addr`/`b_wen`/`b_din`, or drop `b_req`.

**Read latency**
- An access presented in cycle N returns data in cycle N+1 for both ports.
- Back-to-back reads by either port, or alternating between ports, sustain one access per cycle.

**Boundary conditions**
- CPU and secondary both request in the same cycle: the CPU wins, `b_gnt=0`, and the secondary request stays pending.
- A CPU access in cycle N+1 does not disturb `b_rvalid`/`b_rdata` for a secondary read granted in cycle N.
- `rst` asserted mid-access: the tags clear on that edge, so no `b_rvalid` or CPU data capture follows for the in-flight read.
- The downstream controller ignores inputs while `mem_cen=1`; the arbiter never issues a write with `mem_cen=1`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `cpu_cen=0` and `b_req=1` -> `mem_cen=1`, `b_gnt=0`, `cpu_dout=0x0000`, `b_rvalid=0`, `b_starve=0`.
- **CPU priority:** CPU writes `0x1234` to address 5 in cycle N while `b_req=1` -> `b_gnt=0` in N, `mem_addr=5`, `mem_wen=00`. With the CPU idle in N+1 -> `b_gnt=1` in N+1.
- **CPU data hold:** CPU reads address 5 (`0x1234`), then the secondary port reads address 7 (`0xBEEF`) -> `cpu_dout=0x1234` for all following cycles. `b_rvalid=1` with `b_rdata=0xBEEF` exactly one cycle after the grant.
- **Interleaving:** alternate CPU read and secondary read every cycle for 16 cycles -> every `b_rvalid` pulse carries the correct word, and `cpu_dout` matches the model each cycle after each CPU read.
- **Starvation:** with STARVE_MAX=4, hold `cpu_cen=0` and `b_req=1` -> `b_starve=1` after the 4th denied cycle. Pulse `b_clr_starve` -> `b_starve=0` and the count restarts from 0.
- **Reset mid-read:** grant a secondary read in cycle N and assert `rst` in N -> `b_rvalid=0` in N+1.
